// File: rtl/rle_run_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : rle_run_counter_if
// Purpose  : Symbol-in / run-pair-out handshake bundle for the RLE run counter.
//            slave  = the run counter's view, master = the source/sink view.
// Revision : 1.0  initial release
// ============================================================================
interface rle_run_counter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_last
    );
endinterface
`default_nettype wire

// File: rtl/rle_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : rle_run_counter
// Purpose  : Counts consecutive equal symbols and emits (symbol, run length,
//            last) pairs through a single registered output slot.
// Revision : 1.0  initial release
// ============================================================================
module rle_run_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    rle_run_counter_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_max_run = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no open run
        S_ACCUM = 2'd1,   // open run in run_sym_q / run_cnt_q
        S_FLUSH = 2'd2    // one-symbol final run waiting for the output slot
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] run_sym_q, run_sym_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_last_q, out_last_d;

    logic w_slot_free;
    logic w_in_ready;
    logic w_accept;
    logic w_extend;

    // The output slot can take a new pair when it is empty or being drained now.
    assign w_slot_free = !out_valid_q || bus.out_ready;
    assign w_in_ready  = w_slot_free && (state_q != S_FLUSH);
    assign w_accept    = bus.in_valid && w_in_ready;
    // A matching symbol extends the run unless the count is saturated.
    assign w_extend    = (bus.in_data == run_sym_q) && (run_cnt_q != c_max_run);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_last_q;

    // Next-state, run tracking and output-slot load decisions.
    always_comb begin
        state_d     = state_q;
        run_sym_d   = run_sym_q;
        run_cnt_d   = run_cnt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    run_sym_d = bus.in_data;
                    run_cnt_d = c_one;
                    if (bus.in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.in_data;
                        out_count_d = c_one;
                        out_last_d  = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end

            S_ACCUM: begin
                if (w_accept) begin
                    if (w_extend) begin
                        run_cnt_d = run_cnt_q + c_one;
                        if (bus.in_last) begin
                            out_valid_d = 1'b1;
                            out_data_d  = run_sym_q;
                            out_count_d = run_cnt_q + c_one;
                            out_last_d  = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        // Close the current run and open a new one with this symbol.
                        out_valid_d = 1'b1;
                        out_data_d  = run_sym_q;
                        out_count_d = run_cnt_q;
                        out_last_d  = 1'b0;
                        run_sym_d   = bus.in_data;
                        run_cnt_d   = c_one;
                        if (bus.in_last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (w_slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = run_sym_q;
                    out_count_d = c_one;
                    out_last_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, run and output-slot registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run_sym_q   <= '0;
            run_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_sym_q   <= run_sym_d;
            run_cnt_q   <= run_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_run_counter
// Purpose  : Directed self-checking bench for rle_run_counter (DATA_W=8,
//            CNT_W=4). Inputs change and outputs are sampled on falling edges.
// Revision : 1.0  initial release
// ============================================================================
module tb_rle_run_counter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rle_run_counter_if #(.DATA_W(8), .CNT_W(4)) bus ();

    rle_run_counter #(.DATA_W(8), .CNT_W(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                              input logic [3:0] c, input logic l);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".data"},  {24'd0, bus.out_data},  {24'd0, d});
            chk({tag, ".count"}, {28'd0, bus.out_count}, {28'd0, c});
            chk({tag, ".last"},  {31'd0, bus.out_last},  {31'd0, l});
        end
    endtask

    // Present one symbol at a falling edge (must be accepted) and advance to the next.
    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        #1;
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        idle_in();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("rst0", 1'b0, 8'h00, 4'd0, 1'b0);
        chk("rst0.count", {28'd0, bus.out_count}, 32'd0);
        chk("rst0.data",  {24'd0, bus.out_data},  32'd0);
        chk("rst0.in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: reset held 2 cycles in the middle of a run of 0x77
        beat("t1a", 8'h77, 1'b0);
        beat("t1b", 8'h77, 1'b0);
        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("t1.rst", 1'b0, 8'h00, 4'd0, 1'b0);
        chk("t1.count", {28'd0, bus.out_count}, 32'd0);
        chk("t1.in_ready", {31'd0, bus.in_ready}, 32'd1);
        beat("t1c", 8'h42, 1'b1);
        idle_in();
        expect_out("t1.pair", 1'b1, 8'h42, 4'd1, 1'b1);
        @(negedge clk);
        expect_out("t1.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        // 2: A0 A0 A0 B1(last) -> (A0,3,0) then FLUSH (B1,1,1)
        beat("t2a", 8'hA0, 1'b0);
        beat("t2b", 8'hA0, 1'b0);
        expect_out("t2.none", 1'b0, 8'h00, 4'd0, 1'b0);
        beat("t2c", 8'hA0, 1'b0);
        beat("t2d", 8'hB1, 1'b1);
        idle_in();
        expect_out("t2.p0", 1'b1, 8'hA0, 4'd3, 1'b0);
        chk("t2.flush_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        expect_out("t2.p1", 1'b1, 8'hB1, 4'd1, 1'b1);
        chk("t2.ready_back", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        expect_out("t2.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        // 4: single symbol with last from IDLE
        beat("t4", 8'h3C, 1'b1);
        idle_in();
        expect_out("t4.pair", 1'b1, 8'h3C, 4'd1, 1'b1);
        chk("t4.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        expect_out("t4.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        // 3: 17 x 0x55, last on 17 -> (55,15,0), (55,2,1)
        for (int i = 1; i <= 17; i++) begin
            beat("t3", 8'h55, (i == 17));
            if (i == 15) expect_out("t3.nowrap", 1'b0, 8'h00, 4'd0, 1'b0);
            if (i == 16) expect_out("t3.sat", 1'b1, 8'h55, 4'd15, 1'b0);
        end
        idle_in();
        expect_out("t3.tail", 1'b1, 8'h55, 4'd2, 1'b1);
        @(negedge clk);
        expect_out("t3.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        // 5: backpressure on 01 02 03(last)
        bus.out_ready = 1'b0;
        beat("t5a", 8'h01, 1'b0);
        beat("t5b", 8'h02, 1'b0);
        expect_out("t5.held0", 1'b1, 8'h01, 4'd1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        bus.in_last  = 1'b1;
        #1;
        chk("t5.stall0", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        expect_out("t5.held1", 1'b1, 8'h01, 4'd1, 1'b0);
        chk("t5.stall1", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("t5.release", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        idle_in();
        expect_out("t5.p1", 1'b1, 8'h02, 4'd1, 1'b0);
        chk("t5.flush_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        expect_out("t5.p2", 1'b1, 8'h03, 4'd1, 1'b1);
        @(negedge clk);
        expect_out("t5.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        // 6: reset after 5 beats of 0x11 discards the run
        for (int i = 0; i < 5; i++) beat("t6", 8'h11, 1'b0);
        idle_in();
        expect_out("t6.open", 1'b0, 8'h00, 4'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("t6.rst", 1'b0, 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        expect_out("t6.quiet", 1'b0, 8'h00, 4'd0, 1'b0);
        beat("t6a", 8'h11, 1'b0);
        beat("t6b", 8'h11, 1'b1);
        idle_in();
        expect_out("t6.pair", 1'b1, 8'h11, 4'd2, 1'b1);
        @(negedge clk);
        expect_out("t6.drain", 1'b0, 8'h00, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
